// File: rtl/bus_rr_arbiter.sv
// Three-way req/ack bus arbiter feeding the 7-seg decoder, with a grant watchdog.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for fixed 1>2>3 priority.
module bus_rr_arbiter #(
    parameter int unsigned DATA_W  = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req1,
    input  logic              req2,
    input  logic              req3,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    output logic              ack1,
    output logic              ack2,
    output logic              ack3,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        grant_id,
    output logic              timeout_err
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          ack_q, ack_d;
    logic [1:0]          grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                timeout_err_q, timeout_err_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [WDOG_W-1:0]   wdog_inc;

    logic [2:0]          req_vec;
    logic [1:0]          base_c;
    logic [1:0]          cand1, cand2, cand3;
    logic [1:0]          winner_c;

    assign req_vec = {req3, req2, req1};

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd3) ? 2'd1 : id + 2'd1;
    endfunction

    function automatic logic req_of(input logic [1:0] id, input logic [2:0] reqs);
        case (id)
            2'd1:    return reqs[0];
            2'd2:    return reqs[1];
            2'd3:    return reqs[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [1:0] id,
                                                  input logic [DATA_W-1:0] d1,
                                                  input logic [DATA_W-1:0] d2,
                                                  input logic [DATA_W-1:0] d3);
        case (id)
            2'd1:    return d1;
            2'd2:    return d2;
            2'd3:    return d3;
            default: return '0;
        endcase
    endfunction

    function automatic logic [2:0] onehot_of(input logic [1:0] id);
        case (id)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

`ifdef ARB_FIXED_PRIORITY_EN
    // A search base of 3 yields the fixed order 1,2,3.
    assign base_c = 2'd3;
`else
    logic [1:0] ptr_q, ptr_d;

    assign ptr_d = (state_q == ST_IDLE && winner_c != 2'd0) ? winner_c : ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 2'd3;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign base_c = ptr_q;
`endif

    // Search order starts just after the base and wraps 3 -> 1.
    always_comb begin
        cand1    = next_id(base_c);
        cand2    = next_id(cand1);
        cand3    = next_id(cand2);
        winner_c = 2'd0;
        if (req_of(cand1, req_vec)) begin
            winner_c = cand1;
        end else if (req_of(cand2, req_vec)) begin
            winner_c = cand2;
        end else if (req_of(cand3, req_vec)) begin
            winner_c = cand3;
        end
    end

    assign wdog_inc = (wdog_q == WDOG_W'(TIMEOUT)) ? wdog_q : wdog_q + WDOG_W'(1);

    always_comb begin
        state_d       = state_q;
        ack_d         = ack_q;
        grant_id_d    = grant_id_q;
        data_out_d    = data_out_q;
        timeout_err_d = 1'b0;
        wdog_d        = wdog_q;

        unique case (state_q)
            ST_IDLE: begin
                if (winner_c != 2'd0) begin
                    state_d    = ST_GRANT;
                    ack_d      = onehot_of(winner_c);
                    grant_id_d = winner_c;
                    data_out_d = data_of(winner_c, data1, data2, data3);
                    wdog_d     = '0;
                end
            end
            ST_GRANT: begin
                if (!req_of(grant_id_q, req_vec)) begin
                    state_d    = ST_RELEASE;
                    ack_d      = 3'b000;
                    grant_id_d = 2'd0;
                end else begin
                    wdog_d = wdog_inc;
                    // Watchdog: reclaim a grant the master never returned.
                    if (wdog_inc == WDOG_W'(TIMEOUT)) begin
                        state_d       = ST_RELEASE;
                        ack_d         = 3'b000;
                        grant_id_d    = 2'd0;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d    = ST_IDLE;
                ack_d      = 3'b000;
                grant_id_d = 2'd0;
            end
            default: begin
                state_d    = ST_IDLE;
                ack_d      = 3'b000;
                grant_id_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ack_q         <= 3'b000;
            grant_id_q    <= 2'd0;
            data_out_q    <= '0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            grant_id_q    <= grant_id_d;
            data_out_q    <= data_out_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
        end
    end

    assign ack1        = ack_q[0];
    assign ack2        = ack_q[1];
    assign ack3        = ack_q[2];
    assign data_out    = data_out_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: stimulus queues expected grants, a monitor checks them.
module tb_bus_rr_arbiter;

    localparam int unsigned DATA_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req1, req2, req3;
    logic [DATA_W-1:0] data1, data2, data3;
    logic              ack1, ack2, ack3;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        grant_id;
    logic              timeout_err;

    typedef struct {
        int id;
        int data;
    } grant_t;

    grant_t exp_q[$];
    int     n_total = 0;
    int     n_pass  = 0;
    logic [1:0] prev_gid = 2'd0;

    bus_rr_arbiter #(.DATA_W(DATA_W), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req1(req1), .req2(req2), .req3(req3),
        .data1(data1), .data2(data2), .data3(data3),
        .ack1(ack1), .ack2(ack2), .ack3(ack3),
        .data_out(data_out), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bounded wait expired at %0t", name, $time);
    endtask

    function automatic int ack_vec();
        return int'({ack3, ack2, ack1});
    endfunction

    function automatic int onehot_int(input int id);
        return (id == 0) ? 0 : (1 << (id - 1));
    endfunction

    task automatic push_exp(input int id, input int data);
        grant_t g;
        g.id   = id;
        g.data = data;
        exp_q.push_back(g);
    endtask

    // Monitor: every new grant must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            chk("ack_onehot0", int'($onehot0({ack3, ack2, ack1})), 1);
            if (grant_id != 2'd0 && prev_gid == 2'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(grant_id), 0);
                end else begin
                    grant_t g;
                    g = exp_q.pop_front();
                    chk("sb_grant_id", int'(grant_id), g.id);
                    chk("sb_data_out", int'(data_out), g.data);
                    chk("sb_ack_vec", ack_vec(), onehot_int(g.id));
                end
            end
        end
        prev_gid = grant_id;
    end

    task automatic wait_ack(output int id);
        id = 0;
        for (int i = 0; i < 60 && id == 0; i++) begin
            @(negedge clk);
            if (ack1) id = 1;
            else if (ack2) id = 2;
            else if (ack3) id = 3;
        end
        if (id == 0) fail_now("wait_ack");
    endtask

    task automatic wait_no_ack();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!ack1 && !ack2 && !ack3) done = 1'b1;
        end
        if (!done) fail_now("wait_no_ack");
    endtask

    task automatic set_req(input int id, input logic v);
        case (id)
            1: req1 = v;
            2: req2 = v;
            3: req3 = v;
            default: ;
        endcase
    endtask

    // Each master drops req one cycle after its ack, re-raising once the ack falls.
    task automatic run_rounds(input int exp_seq[6]);
        int id;
        for (int g = 0; g < 6; g++) begin
            wait_ack(id);
            chk("round_order", id, exp_seq[g]);
            set_req(id, 1'b0);
            wait_no_ack();
            if (g < 5) set_req(id, 1'b1);
        end
        req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;
    endtask

    initial begin
        int id;
        int ack3_cnt;
        int terr_cnt;
        int seq[6];

        reset = 1'b0;
        req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;
        data1 = '0; data2 = '0; data3 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle after reset: everything low for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", int'({ack3, ack2, ack1, grant_id, data_out, timeout_err}), 0);
        end

        // Single request from master 2, one-cycle grant latency, data held afterwards.
        push_exp(2, 2);
        data2 = 2'b10; req2 = 1'b1;
        @(negedge clk);
        chk("latency_ack2", int'(ack2), 1);
        req2 = 1'b0;
        @(negedge clk);
        chk("drop_ack2", int'(ack2), 0);
        chk("drop_gid", int'(grant_id), 0);
        chk("drop_data_hold", int'(data_out), 2);
        repeat (5) @(negedge clk);
        chk("idle_data_hold", int'(data_out), 2);

        // Async reset while ack2 is high clears outputs without a clock edge.
        push_exp(2, 1);
        data2 = 2'b01; req2 = 1'b1;
        @(negedge clk);
        chk("pre_reset_ack2", int'(ack2), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_ack2", int'(ack2), 0);
        chk("async_gid", int'(grant_id), 0);
        chk("async_data", int'(data_out), 0);
        req2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // All three masters requesting; order starts at 1 after reset.
        data1 = 2'd1; data2 = 2'd2; data3 = 2'd3;
`ifdef ARB_FIXED_PRIORITY_EN
        seq = '{1, 1, 1, 1, 1, 1};
`else
        seq = '{1, 2, 3, 1, 2, 3};
`endif
        for (int g = 0; g < 6; g++) push_exp(seq[g], seq[g]);
        req1 = 1'b1; req2 = 1'b1; req3 = 1'b1;
        run_rounds(seq);
        repeat (3) @(negedge clk);

        // Watchdog: master 3 never drops req; master 1 arrives mid-grant.
        push_exp(3, 3);
        push_exp(1, 2);
        data1 = 2'd2; req3 = 1'b1;
        wait_ack(id);
        chk("wd_first_grant", id, 3);
        ack3_cnt = (id == 3) ? 1 : 0;
        terr_cnt = 0;
        id = 0;
        for (int i = 0; i < 40 && id == 0; i++) begin
            @(negedge clk);
            if (i == 4) req1 = 1'b1;
            if (ack3) ack3_cnt++;
            if (timeout_err) begin
                terr_cnt++;
                chk("wd_ack3_low_on_err", int'(ack3), 0);
                chk("wd_ack3_cycles", ack3_cnt, 15);
            end
            if (ack1) id = 1;
        end
        if (id == 0) fail_now("wd_next_grant");
        chk("wd_err_pulses", terr_cnt, 1);
        chk("wd_total_ack3", ack3_cnt, 15);
        req1 = 1'b0; req3 = 1'b0;
        wait_no_ack();
        repeat (3) @(negedge clk);

`ifdef ARB_FIXED_PRIORITY_EN
        // Fixed priority: master 3 only wins when 1 and 2 are quiet.
        push_exp(3, 1);
        data3 = 2'd1; req3 = 1'b1;
        wait_ack(id);
        chk("fixed_low_prio", id, 3);
        req3 = 1'b0;
        wait_no_ack();
        repeat (3) @(negedge clk);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
